// File: rtl/spart_rx.sv
// SPART receive stage: oversampled 8N1 deserialiser feeding the I/O bus
// with a receive buffer, data-available flag and sticky error flags.
module spart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TLast = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] THalf = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BLast = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 sync1_q, rxd_s;
  logic                 byte_ok, frame_bad;
  logic                 rd_buf, rd_stat;

  assign rd_buf  = iocs && iorw && (ioaddr == 2'b00);
  assign rd_stat = iocs && iorw && (ioaddr == 2'b01);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      sync1_q   <= 1'b1;
      rxd_s     <= 1'b1;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      sync1_q   <= rxd;
      rxd_s     <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (!rxd_s) begin
            state_d = StStart;
            tcnt_d  = '0;
          end
        end
        StStart: begin
          if (tcnt_q == THalf) begin
            tcnt_d = '0;
            if (!rxd_s) begin
              state_d = StData;
              bcnt_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StData: begin
          if (tcnt_q == TLast) begin
            tcnt_d  = '0;
            // LSB arrives first, so each new bit enters at the top
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == BLast) begin
              state_d = StStop;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StStop: begin
          if (tcnt_q == TLast) begin
            tcnt_d  = '0;
            state_d = StIdle;
            if (rxd_s) begin
              byte_ok = 1'b1;
            end else begin
              frame_bad = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Flag sets are applied after clears so a set in the same cycle wins.
  always_comb begin
    rx_data_d = byte_ok ? shift_q : rx_data_q;
    rda_d     = rda_q;
    fe_d      = fe_q;
    ov_d      = ov_q;
    if (rd_buf) rda_d = 1'b0;
    if (rd_stat) begin
      fe_d = 1'b0;
      ov_d = 1'b0;
    end
    if (byte_ok) rda_d = 1'b1;
    if (byte_ok && rda_q) ov_d = 1'b1;
    if (frame_bad) fe_d = 1'b1;
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = fe_q;
  assign overrun     = ov_q;

endmodule
